hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each event counter.
REQ-002 SHALL have parameter REG_W, default 5, register-address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Rs1D  input  REG_W  source-1 address of the instruction in Decode.
REQ-006 SHALL have port Rs2D  input  REG_W  source-2 address of the instruction in Decode.
REQ-007 SHALL have port Rs1E  input  REG_W  source-1 address of the instruction in Execute.
REQ-008 SHALL have port Rs2E  input  REG_W  source-2 address of the instruction in Execute.
REQ-009 SHALL have port RdE  input  REG_W  destination address, output of the decode/execute register.
REQ-010 SHALL have port RegWriteE  input  1  Execute instruction writes RdE.
REQ-011 SHALL have port LoadE  input  1  Execute instruction is a load.
REQ-012 SHALL have port PCSrcE  input  1  taken branch/jump resolved in Execute.
REQ-013 SHALL have port StallF  output  1  hold the PC.
REQ-014 SHALL have port StallD  output  1  hold the fetch/decode register.
REQ-015 SHALL have port FlushD  output  1  clear the fetch/decode register.
REQ-016 SHALL have port FlushE  output  1  clear the decode/execute register (bubble).
REQ-017 SHALL have ports ForwardAE and ForwardBE  output  2  ALU operand source selects: 00 register file, 01 Writeback, 10 Memory.
REQ-018 SHALL have port stall_cnt  output  CNT_W  count of load-use stall cycles.
REQ-019 SHALL have port flush_cnt  output  CNT_W  count of branch-flush cycles.

Function
REQ-020 SHALL hold two internal tracking slots, M {RdM, RegWriteM} and W {RdW, RegWriteW}, which update every cycle: M <= {RdE, RegWriteE}, W <= M. Slots never stall.
REQ-021 SHALL compute the load-use condition lw = LoadE & RegWriteE & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)), combinationally and in the same cycle.
REQ-022 SHALL drive StallF = StallD = lw & ~PCSrcE.
REQ-023 SHALL drive FlushD = PCSrcE.
REQ-024 SHALL drive FlushE = PCSrcE | lw.
REQ-025 On simultaneous PCSrcE and lw, SHALL give priority to the flush: no stall, both flushes asserted.
REQ-026 SHALL drive ForwardAE = 10 when RegWriteM & RdM != 0 & RdM == Rs1E.
REQ-027 Otherwise, SHALL drive ForwardAE = 01 when RegWriteW & RdW != 0 & RdW == Rs1E.
REQ-028 Otherwise, SHALL drive ForwardAE = 00.
REQ-029 SHALL compute ForwardBE identically using Rs2E.
REQ-030 SHALL never forward for register x0.
REQ-031 SHALL have zero latency on all hazard and forward outputs (combinational from inputs and slots).
REQ-032 SHALL increment stall_cnt on each cycle in which StallD = 1.
REQ-033 SHALL increment flush_cnt on each cycle in which FlushD = 1.
REQ-034 SHALL saturate both counters at all-ones, with no wrap-around.

Reset
REQ-035 While rst_n = 0, SHALL asynchronously clear RdM, RdW, RegWriteM, RegWriteW, stall_cnt and flush_cnt to 0.
REQ-036 During reset, combinational outputs SHALL follow the inputs with the slots cleared; ForwardAE/BE = 00 unless the inputs alone create a hazard.
REQ-037 A reset asserted mid-operation SHALL discard all in-flight slot state; no forwarding SHALL occur in the first cycle after release.

Structure
REQ-038 SHALL place a fwd_sel_t enum (FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10) and REG_W in the shared package hazard_pkg.
REQ-039 SHALL implement the forward-select compare as sub-module hazard_fwd_sel, instantiated twice (operands A and B).
REQ-040 SHALL implement the slot and counter registers inline.

Verification
REQ-041 Load x5 in E; Rs1D = 5 -> StallF = StallD = FlushE = 1 and FlushD = 0 for one cycle; stall_cnt goes 0 -> 1.
REQ-042 RegWriteE = 1, RdE = 7; next cycle Rs2E = 7 -> ForwardBE = 10; the cycle after, Rs2E = 7 -> ForwardBE = 01.
REQ-043 M slot and W slot both hold Rd = 3 with writes enabled; Rs1E = 3 -> ForwardAE = 10 (Memory priority).
REQ-044 RdE = 0, LoadE = 1, Rs1D = 0 -> no stall; a later Rs1E = 0 -> ForwardAE = 00.
REQ-045 PCSrcE = 1 together with a load-use hit -> FlushD = FlushE = 1 and StallF = StallD = 0; flush_cnt increments and stall_cnt does not.
REQ-046 Preload flush_cnt to 0xFFFF via repeated flushes; one more flush -> flush_cnt stays 0xFFFF. Assert rst_n = 0 mid-run -> counters and slots read 0 immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
//   REG_W     : register-address width used by the unit and its interface
//   fwd_sel_t : ALU operand source select (register file, Writeback, Memory)
package hazard_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/hazard_if.sv
// Bundle of pipeline-side signals seen by the hazard unit.
//   master : pipeline side, drives the stage addresses/controls, reads stall/flush/forward
//   slave  : hazard unit side
// Inputs : Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, LoadE, PCSrcE
// Outputs: StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
interface hazard_if #(
    parameter int unsigned REG_W = hazard_pkg::REG_W,
    parameter int unsigned CNT_W = 16
);

    logic [REG_W-1:0]     Rs1D;
    logic [REG_W-1:0]     Rs2D;
    logic [REG_W-1:0]     Rs1E;
    logic [REG_W-1:0]     Rs2E;
    logic [REG_W-1:0]     RdE;
    logic                 RegWriteE;
    logic                 LoadE;
    logic                 PCSrcE;

    logic                 StallF;
    logic                 StallD;
    logic                 FlushD;
    logic                 FlushE;
    hazard_pkg::fwd_sel_t ForwardAE;
    hazard_pkg::fwd_sel_t ForwardBE;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, LoadE, PCSrcE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, LoadE, PCSrcE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward-source select for one ALU operand in Execute.
//   rs_e_i        : source address of the Execute operand
//   rd_m_i        : destination held in the Memory tracking slot
//   reg_write_m_i : Memory slot writes its destination
//   rd_w_i        : destination held in the Writeback tracking slot
//   reg_write_w_i : Writeback slot writes its destination
//   fwd_o         : FWD_MEM, FWD_WB or FWD_RF
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned AddrW = REG_W
) (
    input  logic [AddrW-1:0] rs_e_i,
    input  logic [AddrW-1:0] rd_m_i,
    input  logic             reg_write_m_i,
    input  logic [AddrW-1:0] rd_w_i,
    input  logic             reg_write_w_i,
    output fwd_sel_t         fwd_o
);

    // x0 is hardwired; a zero source never forwards. Since rd == rs is required,
    // checking rs != 0 also excludes rd == 0. Memory is the younger producer and wins.
    always_comb begin
        fwd_o = FWD_RF;
        if (rs_e_i != '0) begin
            if (reg_write_m_i && (rd_m_i == rs_e_i)) begin
                fwd_o = FWD_MEM;
            end else if (reg_write_w_i && (rd_w_i == rs_e_i)) begin
                fwd_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall detection, branch flush, operand forwarding
// and saturating event counters.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset, clears tracking slots and counters
//   bus   : hazard_if slave port (stage addresses/controls in, stall/flush/forward/counters out)
// Hazard and forward outputs are purely combinational from the inputs and the two
// tracking slots (M, W), which shadow the pipeline's Memory and Writeback destinations.
module hazard_unit #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned REG_W = hazard_pkg::REG_W
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  bus
);

    logic [REG_W-1:0] rd_m_q;
    logic             reg_write_m_q;
    logic [REG_W-1:0] rd_w_q;
    logic             reg_write_w_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lw_hit;
    logic stall;

    // Load in Execute whose result is needed by the instruction in Decode.
    assign lw_hit = bus.LoadE && bus.RegWriteE && (bus.RdE != '0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    // A taken branch squashes Decode anyway, so stalling would be pointless.
    assign stall = lw_hit && !bus.PCSrcE;

    assign bus.StallF    = stall;
    assign bus.StallD    = stall;
    assign bus.FlushD    = bus.PCSrcE;
    assign bus.FlushE    = bus.PCSrcE || lw_hit;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

    hazard_fwd_sel #(
        .AddrW (REG_W)
    ) u_fwd_a (
        .rs_e_i        (bus.Rs1E),
        .rd_m_i        (rd_m_q),
        .reg_write_m_i (reg_write_m_q),
        .rd_w_i        (rd_w_q),
        .reg_write_w_i (reg_write_w_q),
        .fwd_o         (bus.ForwardAE)
    );

    hazard_fwd_sel #(
        .AddrW (REG_W)
    ) u_fwd_b (
        .rs_e_i        (bus.Rs2E),
        .rd_m_i        (rd_m_q),
        .reg_write_m_i (reg_write_m_q),
        .rd_w_i        (rd_w_q),
        .reg_write_w_i (reg_write_w_q),
        .fwd_o         (bus.ForwardBE)
    );

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bus.PCSrcE && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Tracking slots never stall: they follow the Execute destination every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_m_q        <= '0;
            reg_write_m_q <= 1'b0;
            rd_w_q        <= '0;
            reg_write_w_q <= 1'b0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            rd_m_q        <= bus.RdE;
            reg_write_m_q <= bus.RegWriteE;
            rd_w_q        <= rd_m_q;
            reg_write_w_q <= reg_write_m_q;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: stimulus pushes expected outputs computed by a
// reference model of in-flight writers; a negedge monitor pops and compares.
module tb_hazard_unit;

    localparam int unsigned RegW   = 5;
    localparam int unsigned CntW   = 16;
    localparam int unsigned CntMax = 65535;

    logic clk;
    logic rst_n;

    hazard_if #(.REG_W(RegW), .CNT_W(CntW)) bus ();

    hazard_unit #(
        .CNT_W (CntW),
        .REG_W (RegW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected word: {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, stall_cnt, flush_cnt}
    typedef struct {
        string       tag;
        logic [39:0] v;
    } exp_t;

    typedef struct {
        int rd;
        bit we;
    } wr_t;

    exp_t        sbq[$];
    wr_t         hist[$];   // writers that left Execute, newest first (at most two in flight)
    int unsigned m_stall;
    int unsigned m_flush;
    int          checks;
    int          errors;
    bit          rst_hold;

    exp_t        mon_e;
    logic [39:0] mon_act;

    // Youngest in-flight writer of rs supplies the operand; x0 never forwards.
    function automatic logic [1:0] fwd_of(input int rs);
        if (rs == 0) return 2'b00;
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i].we && hist[i].rd == rs) return (i == 0) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic cycle(input string tag, input int rs1d, input int rs2d, input int rs1e,
                         input int rs2e, input int rde, input bit rwe, input bit lde,
                         input bit pcs);
        exp_t e;
        wr_t  w;
        bit   lw;
        bit   stall;
        @(posedge clk);
        #1;
        rst_n         = !rst_hold;
        bus.Rs1D      = RegW'(rs1d);
        bus.Rs2D      = RegW'(rs2d);
        bus.Rs1E      = RegW'(rs1e);
        bus.Rs2E      = RegW'(rs2e);
        bus.RdE       = RegW'(rde);
        bus.RegWriteE = rwe;
        bus.LoadE     = lde;
        bus.PCSrcE    = pcs;
        if (rst_hold) begin
            hist.delete();
            m_stall = 0;
            m_flush = 0;
        end
        lw    = lde && rwe && (rde != 0) && (rde == rs1d || rde == rs2d);
        stall = lw && !pcs;
        e.tag = tag;
        e.v   = {stall, stall, pcs, pcs || lw, fwd_of(rs1e), fwd_of(rs2e),
                 16'(m_stall), 16'(m_flush)};
        sbq.push_back(e);
        if (!rst_hold) begin
            w.rd = rde;
            w.we = rwe;
            hist.push_front(w);
            if (hist.size() > 2) void'(hist.pop_back());
            if (stall && m_stall < CntMax) m_stall++;
            if (pcs && m_flush < CntMax) m_flush++;
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e   = sbq.pop_front();
            mon_act = {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.ForwardAE,
                       bus.ForwardBE, bus.stall_cnt, bus.flush_cnt};
            checks++;
            if (mon_act !== mon_e.v) begin
                errors++;
                $display("FAIL %s: got %h required %h", mon_e.tag, mon_act, mon_e.v);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        m_stall       = 0;
        m_flush       = 0;
        rst_hold      = 1'b1;
        rst_n         = 1'b0;
        bus.Rs1D      = '0;
        bus.Rs2D      = '0;
        bus.Rs1E      = '0;
        bus.Rs2E      = '0;
        bus.RdE       = '0;
        bus.RegWriteE = 1'b0;
        bus.LoadE     = 1'b0;
        bus.PCSrcE    = 1'b0;

        // Reset state, including a hazard created by the inputs alone.
        cycle("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset_lw",   6, 0, 6, 0, 6, 1, 1, 0);
        rst_hold = 1'b0;
        cycle("post_reset", 0, 0, 6, 6, 0, 0, 0, 0);

        // Load-use stall, then stall_cnt shows 1.
        cycle("lu_stall",   5, 1, 0, 0, 5, 1, 1, 0);
        cycle("lu_cnt",     0, 0, 0, 0, 0, 0, 0, 0);

        // Forward from Memory then Writeback on operand B.
        cycle("fwdb_prod",  0, 0, 0, 0, 7, 1, 0, 0);
        cycle("fwdb_mem",   0, 0, 0, 7, 0, 0, 0, 0);
        cycle("fwdb_wb",    0, 0, 0, 7, 0, 0, 0, 0);

        // Both slots hold x3: Memory wins.
        cycle("fwda_p1",    0, 0, 0, 0, 3, 1, 0, 0);
        cycle("fwda_p2",    0, 0, 0, 0, 3, 1, 0, 0);
        cycle("fwda_prio",  0, 0, 3, 0, 0, 0, 0, 0);

        // x0 never stalls or forwards.
        cycle("x0_load",    0, 0, 0, 0, 0, 1, 1, 0);
        cycle("x0_wr",      0, 0, 0, 0, 0, 1, 0, 0);
        cycle("x0_fwd",     0, 0, 0, 0, 0, 0, 0, 0);

        // Branch flush together with a load-use hit.
        cycle("br_lu",      0, 4, 0, 0, 4, 1, 1, 1);
        cycle("br_lu_cnt",  0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with a reset pulse in the middle.
        for (int i = 0; i < 3000; i++) begin
            rst_hold = (i >= 1500 && i < 1502);
            cycle("random", $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
        end
        rst_hold = 1'b0;

        // Fill flush_cnt to all-ones, then flush more: it must hold.
        while (m_flush < CntMax) begin
            cycle("flush_fill", $urandom_range(0, 7), $urandom_range(0, 7), 0, 0,
                  $urandom_range(0, 7), 1'b1, 1'b0, 1'b1);
        end
        cycle("flush_sat",  0, 0, 0, 0, 0, 0, 0, 1);
        cycle("flush_hold", 0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-run reset discards slots and counters immediately.
        cycle("pre_rst",    0, 0, 0, 0, 9, 1, 0, 0);
        cycle("pre_rst_fw", 0, 0, 9, 0, 9, 1, 0, 0);
        rst_hold = 1'b1;
        cycle("rst_mid",    0, 0, 9, 9, 9, 1, 0, 0);
        rst_hold = 1'b0;
        cycle("rst_release", 0, 0, 9, 9, 9, 1, 0, 0);
        cycle("rst_resume", 0, 0, 9, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
